// File: rtl/chroma_key_ctrl_if.sv
// Register-write port of the chroma-key controller: valid/ready handshake
// carrying a 2-bit address and 8-bit data.
interface chroma_key_ctrl_if;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_wdata;

  modport master (output cfg_valid, output cfg_addr, output cfg_wdata, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_addr, input cfg_wdata, output cfg_ready);
endinterface

// File: rtl/chroma_key_ctrl.sv
// Frame-synchronous chroma-key threshold controller: shadow registers committed
// to the active thresholds on frame_start, plus per-frame pixel statistics.
module chroma_key_ctrl #(
  parameter logic [7:0]  DEF_G_MIN  = 8'd128,
  parameter logic [7:0]  DEF_RG_MAX = 8'd96,
  parameter int unsigned CNT_W      = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  chroma_key_ctrl_if.slave     cfg,
  input  logic                 frame_start,
  input  logic                 i_pixel_valid,
  output logic [7:0]           G_min,
  output logic [7:0]           RG_max,
  output logic                 busy,
  output logic                 commit_done,
  output logic [CNT_W-1:0]     pixel_cnt,
  output logic [15:0]          frame_cnt
);

  typedef enum logic {IDLE, PENDING} state_t;

  state_t           state, state_nxt;
  logic [7:0]       sh_gmin, sh_rgmax;
  logic             sh_key_en;
  logic             wr_acc, commit_req, commit;
  logic [CNT_W-1:0] run_cnt, run_inc;

  assign cfg.cfg_ready = (state == IDLE);
  assign busy          = (state == PENDING);
  assign wr_acc        = cfg.cfg_valid && cfg.cfg_ready;
  assign commit_req    = wr_acc && (cfg.cfg_addr == 2'd2) && cfg.cfg_wdata[1];
  // Only a commit already pending before this edge may use this frame_start.
  assign commit        = (state == PENDING) && frame_start;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (commit_req)  state_nxt = PENDING;
      PENDING: if (frame_start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_gmin   <= DEF_G_MIN;
      sh_rgmax  <= DEF_RG_MAX;
      sh_key_en <= 1'b1;
    end else if (wr_acc) begin
      case (cfg.cfg_addr)
        2'd0:    sh_gmin   <= cfg.cfg_wdata;
        2'd1:    sh_rgmax  <= cfg.cfg_wdata;
        2'd2:    sh_key_en <= cfg.cfg_wdata[0];
        default: ;
      endcase
    end
  end

  // Bypass forces G_min above any expanded green value so nothing is keyed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      G_min       <= DEF_G_MIN;
      RG_max      <= DEF_RG_MAX;
      commit_done <= 1'b0;
    end else begin
      commit_done <= commit;
      if (commit) begin
        G_min  <= sh_key_en ? sh_gmin : 8'hFF;
        RG_max <= sh_rgmax;
      end
    end
  end

  assign run_inc = (i_pixel_valid && (run_cnt != '1)) ? run_cnt + 1'b1 : run_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_cnt   <= '0;
      pixel_cnt <= '0;
      frame_cnt <= '0;
    end else if (frame_start) begin
      pixel_cnt <= run_inc;
      run_cnt   <= '0;
      frame_cnt <= frame_cnt + 16'd1;
    end else begin
      run_cnt   <= run_inc;
    end
  end

endmodule

// File: tb/tb_chroma_key_ctrl.sv
// Directed bench for chroma_key_ctrl: commit timing, bypass, collisions,
// reset mid-commit, pixel/frame statistics and counter boundaries.
module tb_chroma_key_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        frame_start = 1'b0;
  logic        i_pixel_valid = 1'b0;
  logic [7:0]  G_min, RG_max, G_min_s, RG_max_s;
  logic        busy, commit_done, busy_s, commit_done_s;
  logic [19:0] pixel_cnt;
  logic [3:0]  pixel_cnt_s;
  logic [15:0] frame_cnt, frame_cnt_s;
  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  chroma_key_ctrl_if bus ();
  chroma_key_ctrl_if bus_s ();

  always #5 clk = ~clk;

  chroma_key_ctrl dut (
    .clk(clk), .rst(rst), .cfg(bus.slave), .frame_start(frame_start),
    .i_pixel_valid(i_pixel_valid), .G_min(G_min), .RG_max(RG_max), .busy(busy),
    .commit_done(commit_done), .pixel_cnt(pixel_cnt), .frame_cnt(frame_cnt)
  );

  // Narrow counter instance to reach pixel-count saturation quickly.
  chroma_key_ctrl #(.CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .cfg(bus_s.slave), .frame_start(frame_start),
    .i_pixel_valid(i_pixel_valid), .G_min(G_min_s), .RG_max(RG_max_s), .busy(busy_s),
    .commit_done(commit_done_s), .pixel_cnt(pixel_cnt_s), .frame_cnt(frame_cnt_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
    int unsigned n = 0;
    bus.cfg_valid = 1'b1;
    bus.cfg_addr  = a;
    bus.cfg_wdata = d;
    while (!bus.cfg_ready && n < 50) begin
      tick();
      n++;
    end
    if (!bus.cfg_ready) check("wr_timeout", 32'(bus.cfg_ready), 32'd1);
    tick();
    bus.cfg_valid = 1'b0;
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    bus.cfg_valid   = 1'b0;
    bus.cfg_addr    = 2'd0;
    bus.cfg_wdata   = 8'd0;
    bus_s.cfg_valid = 1'b0;
    bus_s.cfg_addr  = 2'd0;
    bus_s.cfg_wdata = 8'd0;
    do_reset();
    repeat (10) tick();
    check("rst_gmin",  32'(G_min), 32'd128);
    check("rst_rgmax", 32'(RG_max), 32'd96);
    check("rst_ready", 32'(bus.cfg_ready), 32'd1);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_done",  32'(commit_done), 32'd0);
    check("rst_pix",   32'(pixel_cnt), 32'd0);
    check("rst_frm",   32'(frame_cnt), 32'd0);

    // basic commit
    cfg_write(2'd0, 8'h90);
    cfg_write(2'd1, 8'h40);
    check("shadow_no_effect", 32'(G_min), 32'd128);
    cfg_write(2'd2, 8'h03);
    check("pend_busy",  32'(busy), 32'd1);
    check("pend_ready", 32'(bus.cfg_ready), 32'd0);
    repeat (20) tick();
    check("pend_gmin",  32'(G_min), 32'd128);
    check("pend_rgmax", 32'(RG_max), 32'd96);
    pulse_fs();
    check("c1_gmin",  32'(G_min), 32'h90);
    check("c1_rgmax", 32'(RG_max), 32'h40);
    check("c1_done",  32'(commit_done), 32'd1);
    check("c1_busy",  32'(busy), 32'd0);
    tick();
    check("c1_done_drop", 32'(commit_done), 32'd0);

    // key disable then re-enable
    cfg_write(2'd2, 8'h02);
    pulse_fs();
    check("byp_gmin",  32'(G_min), 32'hFF);
    check("byp_rgmax", 32'(RG_max), 32'h40);
    cfg_write(2'd2, 8'h03);
    pulse_fs();
    check("reen_gmin", 32'(G_min), 32'h90);

    // idle frame_start does nothing
    pulse_fs();
    check("idle_fs_done", 32'(commit_done), 32'd0);
    check("idle_fs_gmin", 32'(G_min), 32'h90);

    // commit write colliding with frame_start
    cfg_write(2'd0, 8'h70);
    bus.cfg_valid = 1'b1;
    bus.cfg_addr  = 2'd2;
    bus.cfg_wdata = 8'h03;
    frame_start   = 1'b1;
    tick();
    bus.cfg_valid = 1'b0;
    frame_start   = 1'b0;
    check("coll_busy", 32'(busy), 32'd1);
    check("coll_done", 32'(commit_done), 32'd0);
    check("coll_gmin", 32'(G_min), 32'h90);
    // write held during PENDING stalls until after the commit
    bus.cfg_valid = 1'b1;
    bus.cfg_addr  = 2'd0;
    bus.cfg_wdata = 8'h55;
    repeat (3) tick();
    check("stall_ready", 32'(bus.cfg_ready), 32'd0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("coll_c_gmin",  32'(G_min), 32'h70);
    check("coll_c_done",  32'(commit_done), 32'd1);
    check("coll_c_ready", 32'(bus.cfg_ready), 32'd1);
    tick();
    bus.cfg_valid = 1'b0;
    cfg_write(2'd2, 8'h03);
    pulse_fs();
    check("stall_wr_gmin", 32'(G_min), 32'h55);

    // reset during PENDING
    cfg_write(2'd0, 8'h11);
    cfg_write(2'd1, 8'h22);
    cfg_write(2'd2, 8'h03);
    check("rp_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check("rp_gmin",  32'(G_min), 32'd128);
    check("rp_rgmax", 32'(RG_max), 32'd96);
    check("rp_busy0", 32'(busy), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    pulse_fs();
    check("rp_fs_done", 32'(commit_done), 32'd0);
    check("rp_fs_gmin", 32'(G_min), 32'd128);

    // pixel statistics: 640 valid per frame, last one in the frame_start cycle
    do_reset();
    for (int f = 1; f <= 3; f++) begin
      i_pixel_valid = 1'b1;
      repeat (639) tick();
      frame_start = 1'b1;
      tick();
      frame_start   = 1'b0;
      i_pixel_valid = 1'b0;
      check("pix_cnt", 32'(pixel_cnt), 32'd640);
      check("frm_cnt", 32'(frame_cnt), 32'(f));
      if (f == 1) check("pix_sat", 32'(pixel_cnt_s), 32'd15);
    end
    // frame without pixels and not-yet-ended frame
    i_pixel_valid = 1'b1;
    repeat (5) tick();
    check("pix_hold", 32'(pixel_cnt), 32'd640);
    i_pixel_valid = 1'b0;
    pulse_fs();
    check("pix_five", 32'(pixel_cnt), 32'd5);

    // frame counter wrap
    do_reset();
    frame_start = 1'b1;
    repeat (65535) tick();
    check("frm_max", 32'(frame_cnt), 32'hFFFF);
    tick();
    frame_start = 1'b0;
    check("frm_wrap", 32'(frame_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/chroma_key_ctrl.md
# chroma_key_ctrl

Frame-synchronous configuration controller for the chroma-key mixer stage. It holds shadow copies of the green-key thresholds, which are written over a valid/ready register port. On request, it commits them to the active outputs only at a frame boundary, so the keyed region never changes mid-frame. It also produces a key-disable (bypass) threshold and per-frame pixel statistics for software and debug.

## Interface
- DEF_G_MIN, 8'd128, reset/default value of active and shadow G_min
- DEF_RG_MAX, 8'd96, reset/default value of active and shadow RG_max
- CNT_W, 20, width of pixel counter
- clk  in  1  pixel clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- cfg_valid  in  1  register write request
- cfg_ready  out  1  controller can accept a write (combinational from state)
- cfg_addr  in  2  0 = G_min, 1 = RG_max, 2 = CTRL, 3 = reserved
- cfg_wdata  in  8  write data; CTRL bit0 = key_en, bit1 = commit request
- frame_start  in  1  single-cycle pulse at start of each frame (vsync edge from capture)
- i_pixel_valid  in  1  pixel strobe, same signal that feeds the mixer
- G_min  out  8  active green minimum threshold to mixer, registered
- RG_max  out  8  active red/blue maximum threshold to mixer, registered
- busy  out  1  commit pending
- commit_done  out  1  one-cycle pulse when shadow values become active
- pixel_cnt  out  CNT_W  valid pixels counted in the last completed frame
- frame_cnt  out  16  frames seen since reset, wraps

## Operation
- State machine has two states:
  - IDLE: cfg_ready = 1.
  - PENDING: cfg_ready = 0, busy = 1.
- A write is accepted on a clock edge where cfg_valid && cfg_ready.
  - addr 0 loads sh_gmin.
  - addr 1 loads sh_rgmax.
  - addr 2 loads sh_key_en from bit0. If bit1 = 1, the state moves IDLE -> PENDING.
  - addr 3 is accepted and ignored.
- Shadow writes never alter outputs directly.
- PENDING -> IDLE on frame_start. On that edge: act_gmin <= sh_gmin, act_rgmax <= sh_rgmax, act_key_en <= sh_key_en, and commit_done = 1 for one cycle.
- Output mapping:
  - G_min = act_key_en ? act_gmin : 8'hFF. Bypass works because the mixer's 4-bit-expanded green never exceeds 8'hF0, so no pixel is keyed.
  - RG_max = act_rgmax, unaffected by key_en.
- Pixel counter:
  - Increments on each i_pixel_valid and saturates at all-ones (no wrap).
  - On frame_start, pixel_cnt <= current count (including a valid pixel in that same cycle), and the running count reloads to 0.
  - If i_pixel_valid coincides with frame_start, the running count reloads to 0 and that pixel is counted in the old frame, i.e. latched into pixel_cnt.
- frame_cnt increments on every frame_start and wraps 16'hFFFF -> 0.
- Simultaneous events:
  - A commit write and frame_start on the same edge: the write is accepted and the state enters PENDING. That frame_start does not commit; the commit happens on the next frame_start.
  - frame_start while in IDLE: no threshold change and no commit_done.
  - A write while in PENDING is not accepted (cfg_ready = 0). The master must hold cfg_valid.
- Reset (asserted at any time, including mid-commit):
  - State returns to IDLE.
  - Shadow and active registers return to DEF_G_MIN / DEF_RG_MAX, with key_en = 1.
  - The pending commit is discarded.

## Timing
- Reset values:
  - G_min = DEF_G_MIN, RG_max = DEF_RG_MAX.
  - busy = 0, commit_done = 0, pixel_cnt = 0, frame_cnt = 0.
  - cfg_ready = 1.
- Commit write accepted at edge N: busy = 1 and cfg_ready = 0 from N+1.
- frame_start sampled high at edge M > N:
  - New G_min/RG_max, commit_done = 1 and busy = 0 are visible after edge M.
  - commit_done drops after M+1.
- pixel_cnt and frame_cnt update on the same edge that samples frame_start.
- All outputs are registered except cfg_ready.

## Test plan
- Reset, then idle for 10 cycles -> G_min = 128, RG_max = 96, cfg_ready = 1, busy = 0, counters = 0.
- Write G_min = 8'h90, RG_max = 8'h40, CTRL = 8'h03, then pulse frame_start 20 cycles later -> outputs stay 128/96 until the edge that samples frame_start, then become 8'h90/8'h40. commit_done is high for exactly 1 cycle, busy goes 1 -> 0.
- CTRL = 8'h02 (key_en = 0) then commit at frame_start -> G_min = 8'hFF, RG_max unchanged.
  - Then CTRL = 8'h03 and commit -> G_min returns to the shadow value.
- CTRL commit write on the same edge as frame_start -> no change on that frame. Commit occurs on the following frame_start.
  - A G_min write held on cfg_valid during PENDING stalls (cfg_ready = 0) and is accepted on the cycle after the commit.
- 3 frames of 640 valid pixels each, with i_pixel_valid also high in the frame_start cycle -> pixel_cnt = 640 after each frame, frame_cnt = 1, 2, 3.
- Assert rst mid-PENDING after writing new shadow values -> outputs return to 128/96. A following frame_start produces no commit_done.
